// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel, WIDTH-bit registered multiplexer with valid/ready
// on every input channel and on the single output stage.
//
// Selection is either static (mode=0, channel = sel) or round-robin among
// valid channels (mode=1, scan starts at the rr pointer). One output
// register gives one-cycle latency and sustains 1 word/clk when the
// consumer keeps out_ready high.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mode                0 = static select, 1 = round-robin
//   sel [SELW]          channel index used when mode=0 (>= NCH never grants)
//   in_data [NCH*WIDTH] channel i at bits [i*WIDTH +: WIDTH]
//   in_valid/in_ready   per-channel handshake; in_ready is one-hot or zero
//   out_data/out_sel    registered word and the channel that supplied it
//   out_valid/out_ready output handshake
//   xfer_count [16]     only with MUX_RR_N_STATS_EN: completed output
//                       handshakes, wrapping at 16'hFFFF
module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_RR_N_STATS_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  logic [SELW-1:0]  rr_ptr;
  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [NCH-1:0]   gnt_oh;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  // Register is free, or is being drained this same cycle.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    if (!mode) begin
      // Compare against each legal index so sel >= NCH simply matches nothing.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld   = 1'b1;
          gnt_idx   = SELW'(i);
          gnt_oh[i] = 1'b1;
        end
      end
    end else begin
      // Scan p, p+1, ..., NCH-1, 0, ..., p-1; wrap on NCH, not 2**SELW.
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld     = 1'b1;
          gnt_idx     = SELW'(idx);
          gnt_oh[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt_oh[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  // A grant already implies in_valid, so any raised in_ready is a transfer.
  assign in_ready = (!reset && load_en && gnt_vld) ? gnt_oh : '0;
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        if (mode)
          rr_ptr <= (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + SELW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_N_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                         xfer_count <= '0;
    else if (out_valid && out_ready)   xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule
